// File: rtl/facto_pkg.sv
// Shared definitions for the factorial-accelerator initiator: register map,
// OPDONE status bits and the sequencing FSM state encoding.
package facto_pkg;

    localparam logic [7:0] OFS_OPSTART  = 8'h00;
    localparam logic [7:0] OFS_OPCLEAR  = 8'h08;
    localparam logic [7:0] OFS_OPDONE   = 8'h10;
    localparam logic [7:0] OFS_INTREN   = 8'h18;
    localparam logic [7:0] OFS_OPERAND  = 8'h20;
    localparam logic [7:0] OFS_RESULT_H = 8'h28;
    localparam logic [7:0] OFS_RESULT_L = 8'h30;

    localparam int unsigned DONE_BIT = 0;
    localparam int unsigned BUSY_BIT = 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_W_OPND,
        ST_W_INTR,
        ST_W_START,
        ST_WAIT_INT,
        ST_POLL,
        ST_POLL_WT,
        ST_GAP,
        ST_R_H,
        ST_R_H_WT,
        ST_R_L,
        ST_R_L_WT,
        ST_W_CLR,
        ST_W_UNCLR,
        ST_W_INTR_OFF,
        ST_RESP
    } facto_state_e;

endpackage

// File: rtl/facto_bus_beat.sv
// Bus beat engine: turns a held beat request into a single granted m_sel beat
// and flags the cycle in which read data is present on m_din.
module facto_bus_beat
    import facto_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        bus_req,
    input  logic        beat_go,
    input  logic        beat_wr,
    input  logic [7:0]  beat_ofs,
    input  logic [63:0] beat_wdata,
    output logic        beat_done,
    output logic        beat_rvalid,
    output logic [63:0] beat_rdata,
    output logic        m_req,
    input  logic        m_grant,
    output logic        m_sel,
    output logic        m_wr,
    output logic [15:0] m_addr,
    output logic [63:0] m_dout,
    input  logic [63:0] m_din
);

    logic rd_pend_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend_q <= 1'b0;
        end else begin
            rd_pend_q <= beat_done & ~beat_wr;
        end
    end

    // Address/data are held for as long as the FSM holds beat_go, so a stalled
    // grant leaves them stable; only m_sel depends on the grant.
    always_comb begin
        m_req       = bus_req;
        m_sel       = beat_go & m_grant;
        beat_done   = beat_go & m_grant;
        m_wr        = beat_go & beat_wr;
        m_addr      = beat_go ? (BASE_ADDR + {8'h00, beat_ofs}) : '0;
        m_dout      = beat_go ? beat_wdata : '0;
        beat_rvalid = rd_pend_q;
        beat_rdata  = m_din;
    end

endmodule

// File: rtl/facto_initiator.sv
// Bus master running one factorial job on the accelerator: program, poll, read, clear.
// Define FACTO_INITIATOR_INTR_EN to wait on the intr input instead of timed OPDONE polling.
module facto_initiator
    import facto_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int unsigned POLL_GAP  = 4,
    parameter int unsigned POLL_MAX  = 1024
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [63:0]  cmd_operand,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_result,
    output logic         rsp_err,
`ifdef FACTO_INITIATOR_INTR_EN
    input  logic         intr,
`endif
    output logic         m_req,
    input  logic         m_grant,
    output logic         m_sel,
    output logic         m_wr,
    output logic [15:0]  m_addr,
    output logic [63:0]  m_dout,
    input  logic [63:0]  m_din
);

    localparam int unsigned POLL_CAP   = (POLL_MAX > 65535) ? 65535 : POLL_MAX;
    localparam logic [15:0] POLL_LIMIT = 16'(POLL_CAP);
    localparam logic [15:0] GAP_LAST   = (POLL_GAP > 0) ? 16'(POLL_GAP - 1) : 16'h0000;
`ifdef FACTO_INITIATOR_INTR_EN
    localparam logic [31:0] WAIT_LIMIT = 32'(POLL_MAX * (POLL_GAP + 1));
`endif

    facto_state_e state_q, state_d;
    logic [63:0]  operand_q, operand_d;
    logic [127:0] result_q, result_d;
    logic         err_q, err_d;
    logic [15:0]  poll_cnt_q, poll_cnt_d;
    logic [15:0]  gap_cnt_q, gap_cnt_d;
`ifdef FACTO_INITIATOR_INTR_EN
    logic [31:0]  wait_cnt_q, wait_cnt_d;
`endif

    logic         bus_req;
    logic         beat_go;
    logic         beat_wr;
    logic [7:0]   beat_ofs;
    logic [63:0]  beat_wdata;
    logic         beat_done;
    logic         beat_rvalid;
    logic [63:0]  beat_rdata;

    facto_bus_beat #(
        .BASE_ADDR (BASE_ADDR)
    ) u_beat (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus_req     (bus_req),
        .beat_go     (beat_go),
        .beat_wr     (beat_wr),
        .beat_ofs    (beat_ofs),
        .beat_wdata  (beat_wdata),
        .beat_done   (beat_done),
        .beat_rvalid (beat_rvalid),
        .beat_rdata  (beat_rdata),
        .m_req       (m_req),
        .m_grant     (m_grant),
        .m_sel       (m_sel),
        .m_wr        (m_wr),
        .m_addr      (m_addr),
        .m_dout      (m_dout),
        .m_din       (m_din)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            operand_q  <= '0;
            result_q   <= '0;
            err_q      <= 1'b0;
            poll_cnt_q <= '0;
            gap_cnt_q  <= '0;
`ifdef FACTO_INITIATOR_INTR_EN
            wait_cnt_q <= '0;
`endif
        end else begin
            operand_q  <= operand_d;
            result_q   <= result_d;
            err_q      <= err_d;
            poll_cnt_q <= poll_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
`ifdef FACTO_INITIATOR_INTR_EN
            wait_cnt_q <= wait_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        operand_d  = operand_q;
        result_d   = result_q;
        err_d      = err_q;
        poll_cnt_d = poll_cnt_q;
        gap_cnt_d  = gap_cnt_q;
`ifdef FACTO_INITIATOR_INTR_EN
        wait_cnt_d = wait_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // Result is cleared per job so a timeout returns zero.
                if (cmd_valid) begin
                    operand_d  = cmd_operand;
                    result_d   = '0;
                    err_d      = 1'b0;
                    poll_cnt_d = '0;
                    gap_cnt_d  = '0;
`ifdef FACTO_INITIATOR_INTR_EN
                    wait_cnt_d = '0;
`endif
                    state_d    = ST_W_OPND;
                end
            end
            ST_W_OPND: begin
                if (beat_done) begin
`ifdef FACTO_INITIATOR_INTR_EN
                    state_d = ST_W_INTR;
`else
                    state_d = ST_W_START;
`endif
                end
            end
            ST_W_INTR: begin
                if (beat_done) state_d = ST_W_START;
            end
            ST_W_START: begin
                if (beat_done) begin
`ifdef FACTO_INITIATOR_INTR_EN
                    state_d = ST_WAIT_INT;
`else
                    state_d = ST_POLL;
`endif
                end
            end
`ifdef FACTO_INITIATOR_INTR_EN
            ST_WAIT_INT: begin
                if (intr) begin
                    state_d = ST_POLL;
                end else if (wait_cnt_q == WAIT_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = ST_W_CLR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                end
            end
`endif
            ST_POLL: begin
                if (beat_done) begin
                    if (poll_cnt_q != 16'hFFFF) poll_cnt_d = poll_cnt_q + 16'd1;
                    state_d = ST_POLL_WT;
                end
            end
            ST_POLL_WT: begin
                if (beat_rvalid) begin
                    if (beat_rdata[DONE_BIT]) begin
                        state_d = ST_R_H;
`ifdef FACTO_INITIATOR_INTR_EN
                    end else begin
                        state_d = ST_WAIT_INT;
                    end
`else
                    end else if (poll_cnt_q == POLL_LIMIT) begin
                        err_d   = 1'b1;
                        state_d = ST_W_CLR;
                    end else if (POLL_GAP == 0) begin
                        state_d = ST_POLL;
                    end else begin
                        gap_cnt_d = '0;
                        state_d   = ST_GAP;
                    end
`endif
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_POLL;
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end
            ST_R_H: begin
                if (beat_done) state_d = ST_R_H_WT;
            end
            ST_R_H_WT: begin
                if (beat_rvalid) begin
                    result_d[127:64] = beat_rdata;
                    state_d          = ST_R_L;
                end
            end
            ST_R_L: begin
                if (beat_done) state_d = ST_R_L_WT;
            end
            ST_R_L_WT: begin
                if (beat_rvalid) begin
                    result_d[63:0] = beat_rdata;
                    state_d        = ST_W_CLR;
                end
            end
            ST_W_CLR: begin
                if (beat_done) state_d = ST_W_UNCLR;
            end
            ST_W_UNCLR: begin
                if (beat_done) begin
`ifdef FACTO_INITIATOR_INTR_EN
                    state_d = ST_W_INTR_OFF;
`else
                    state_d = ST_RESP;
`endif
                end
            end
            ST_W_INTR_OFF: begin
                if (beat_done) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus_req    = 1'b0;
        beat_go    = 1'b0;
        beat_wr    = 1'b0;
        beat_ofs   = '0;
        beat_wdata = '0;
        cmd_ready  = (state_q == ST_IDLE);
        rsp_valid  = (state_q == ST_RESP);
        rsp_result = result_q;
        rsp_err    = err_q;
        case (state_q)
            ST_W_OPND: begin
                bus_req    = 1'b1;
                beat_go    = 1'b1;
                beat_wr    = 1'b1;
                beat_ofs   = OFS_OPERAND;
                beat_wdata = operand_q;
            end
            ST_W_INTR: begin
                bus_req    = 1'b1;
                beat_go    = 1'b1;
                beat_wr    = 1'b1;
                beat_ofs   = OFS_INTREN;
                beat_wdata = 64'd1;
            end
            ST_W_START: begin
                bus_req    = 1'b1;
                beat_go    = 1'b1;
                beat_wr    = 1'b1;
                beat_ofs   = OFS_OPSTART;
                beat_wdata = 64'd1;
            end
            ST_POLL: begin
                bus_req  = 1'b1;
                beat_go  = 1'b1;
                beat_ofs = OFS_OPDONE;
            end
            ST_R_H: begin
                bus_req  = 1'b1;
                beat_go  = 1'b1;
                beat_ofs = OFS_RESULT_H;
            end
            ST_R_L: begin
                bus_req  = 1'b1;
                beat_go  = 1'b1;
                beat_ofs = OFS_RESULT_L;
            end
            ST_POLL_WT, ST_R_H_WT, ST_R_L_WT: begin
                bus_req = 1'b1;
            end
            ST_W_CLR: begin
                bus_req    = 1'b1;
                beat_go    = 1'b1;
                beat_wr    = 1'b1;
                beat_ofs   = OFS_OPCLEAR;
                beat_wdata = 64'd1;
            end
            ST_W_UNCLR: begin
                bus_req    = 1'b1;
                beat_go    = 1'b1;
                beat_wr    = 1'b1;
                beat_ofs   = OFS_OPCLEAR;
                beat_wdata = 64'd0;
            end
            ST_W_INTR_OFF: begin
                bus_req    = 1'b1;
                beat_go    = 1'b1;
                beat_wr    = 1'b1;
                beat_ofs   = OFS_INTREN;
                beat_wdata = 64'd0;
            end
            default: begin
                bus_req = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_facto_initiator.sv
// Directed bench for facto_initiator against a behavioural accelerator slave model.
`timescale 1ns/1ps
module tb_facto_initiator;

    localparam logic [15:0] BASE = 16'h0400;
    localparam int unsigned GAP  = 4;
    localparam int unsigned PMAX = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [63:0]  cmd_operand = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [127:0] rsp_result;
    logic         rsp_err;
    logic         m_req;
    logic         m_grant = 1'b0;
    logic         m_sel;
    logic         m_wr;
    logic [15:0]  m_addr;
    logic [63:0]  m_dout;
    logic [63:0]  m_din;

    always #5 clk = ~clk;

    facto_initiator #(
        .BASE_ADDR (BASE),
        .POLL_GAP  (GAP),
        .POLL_MAX  (PMAX)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_operand (cmd_operand),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_err     (rsp_err),
        .m_req       (m_req),
        .m_grant     (m_grant),
        .m_sel       (m_sel),
        .m_wr        (m_wr),
        .m_addr      (m_addr),
        .m_dout      (m_dout),
        .m_din       (m_din)
    );

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned done_dly = 0;
    int unsigned start_cyc;
    logic        started;
    logic [63:0] s_operand;
    logic [127:0] s_fact;

    logic [15:0] log_addr[$];
    logic        log_wr[$];
    logic [63:0] log_data[$];
    int unsigned log_cyc[$];

    function automatic logic [127:0] fact(input logic [63:0] n);
        logic [127:0] r = 128'd1;
        for (int i = 2; i <= 34; i++) begin
            if (64'(i) <= n) r = r * 128'(i);
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always_comb s_fact = fact(s_operand);

    // Accelerator slave: read data appears exactly one cycle after the read beat.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_din     <= '0;
            started   <= 1'b0;
            s_operand <= '0;
            start_cyc <= 0;
        end else begin
            m_din <= 64'hDEAD_BEEF_0BAD_F00E;
            if (m_sel) begin
                log_addr.push_back(m_addr);
                log_wr.push_back(m_wr);
                log_data.push_back(m_dout);
                log_cyc.push_back(cyc);
                if (m_wr) begin
                    case (m_addr - BASE)
                        16'h0020: s_operand <= m_dout;
                        16'h0000: if (m_dout[0]) begin started <= 1'b1; start_cyc <= cyc; end
                        16'h0008: if (m_dout[0]) started <= 1'b0;
                        default: ;
                    endcase
                end else begin
                    case (m_addr - BASE)
                        16'h0010: m_din <= (started && (cyc - start_cyc) >= done_dly) ? 64'd3 : 64'd0;
                        16'h0028: m_din <= s_fact[127:64];
                        16'h0030: m_din <= s_fact[63:0];
                        default:  m_din <= '0;
                    endcase
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input int i, input logic [7:0] ofs,
                            input logic wr, input logic [63:0] dat);
        chk($sformatf("%s_beat%0d_present", tag, i), 128'(log_addr.size() > i), 128'd1);
        if (log_addr.size() > i) begin
            chk($sformatf("%s_beat%0d_addr", tag, i), 128'(log_addr[i]), 128'(BASE + {8'h00, ofs}));
            chk($sformatf("%s_beat%0d_wr", tag, i), 128'(log_wr[i]), 128'(wr));
            if (wr) chk($sformatf("%s_beat%0d_data", tag, i), 128'(log_data[i]), 128'(dat));
        end
    endtask

    task automatic chk_poll_spacing(input string tag);
        if (log_cyc.size() >= 6) begin
            for (int i = 3; i <= 5; i++)
                chk($sformatf("%s_poll_spacing%0d", tag, i), 128'(log_cyc[i] - log_cyc[i-1]), 128'(GAP + 2));
        end
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_wr.delete();
        log_data.delete();
        log_cyc.delete();
    endtask

    // Leaves the caller just after the accepting clock edge.
    task automatic send(input logic [63:0] op);
        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_operand = op;
        @(posedge clk);
    endtask

    task automatic wait_rsp(input string tag, output int lat);
        int n = 0;
        do begin
            @(negedge clk);
            cmd_valid = 1'b0;
            n++;
        end while (!rsp_valid && n < 200);
        lat = n;
        chk({tag, "_rsp_valid"}, 128'(rsp_valid), 128'd1);
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    logic [7:0]  expA_ofs [10] = '{8'h20, 8'h00, 8'h10, 8'h10, 8'h10, 8'h10, 8'h28, 8'h30, 8'h08, 8'h08};
    logic        expA_wr  [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [63:0] expA_dat [10] = '{64'd5, 64'd1, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd1, 64'd0};
    logic [7:0]  expF_ofs [8]  = '{8'h20, 8'h00, 8'h10, 8'h10, 8'h10, 8'h10, 8'h08, 8'h08};
    logic        expF_wr  [8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [63:0] expF_dat [8]  = '{64'd7, 64'd1, 64'd0, 64'd0, 64'd0, 64'd0, 64'd1, 64'd0};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int nstart;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 128'(cmd_ready), 128'd1);
        chk("rst_m_req", 128'(m_req), 128'd0);
        chk("rst_m_sel", 128'(m_sel), 128'd0);
        chk("rst_rsp_valid", 128'(rsp_valid), 128'd0);
        chk("rst_rsp_result", rsp_result, 128'd0);
        chk("rst_rsp_err", 128'(rsp_err), 128'd0);
        chk("rst_m_addr", 128'(m_addr), 128'd0);
        chk("rst_m_dout", 128'(m_dout), 128'd0);
        reset_n = 1'b1;
        m_grant = 1'b1;

        // Operand 5, done seen on the fourth poll
        done_dly = 15;
        clear_log();
        send(64'd5);
        wait_rsp("A", lat);
        chk("A_result", rsp_result, 128'd120);
        chk("A_err", 128'(rsp_err), 128'd0);
        chk("A_nbeats", 128'(log_addr.size()), 128'd10);
        for (int i = 0; i < 10; i++) chk_beat("A", i, expA_ofs[i], expA_wr[i], expA_dat[i]);
        chk_poll_spacing("A");
        ack();

        // Operand 0, instant done: minimum latency
        done_dly = 0;
        clear_log();
        send(64'd0);
        wait_rsp("B", lat);
        chk("B_result", rsp_result, 128'd1);
        chk("B_latency", 128'(lat), 128'd11);
        chk("B_nbeats", 128'(log_addr.size()), 128'd7);
        ack();

        send(64'd20);
        wait_rsp("C", lat);
        chk("C_result", rsp_result, 128'h21C3677C82B40000);
        chk("C_err", 128'(rsp_err), 128'd0);
        ack();

        send(64'd21);
        wait_rsp("D", lat);
        chk("D_result", rsp_result, 128'd51090942171709440000);
        ack();

        // Grant withheld while W_START is pending
        clear_log();
        send(64'd3);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk);
        #1 m_grant = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("E_sel_low", 128'(m_sel), 128'd0);
            chk("E_addr", 128'(m_addr), 128'(BASE));
            chk("E_dout", 128'(m_dout), 128'd1);
            chk("E_wr", 128'(m_wr), 128'd1);
            chk("E_req", 128'(m_req), 128'd1);
        end
        m_grant = 1'b1;
        #1;
        chk("E_sel_grant", 128'(m_sel), 128'd1);
        wait_rsp("E", lat);
        chk("E_result", rsp_result, 128'd6);
        nstart = 0;
        foreach (log_addr[i]) if (log_addr[i] == BASE && log_wr[i]) nstart++;
        chk("E_one_opstart", 128'(nstart), 128'd1);
        ack();

        // OPDONE never set: timeout after PMAX polls, clear sequence still runs
        done_dly = 32'hFFFF_FFFF;
        clear_log();
        send(64'd7);
        wait_rsp("F", lat);
        chk("F_err", 128'(rsp_err), 128'd1);
        chk("F_result", rsp_result, 128'd0);
        chk("F_nbeats", 128'(log_addr.size()), 128'd8);
        for (int i = 0; i < 8; i++) chk_beat("F", i, expF_ofs[i], expF_wr[i], expF_dat[i]);
        chk_poll_spacing("F");
        ack();

        // Response back-pressure with a second command waiting
        done_dly = 0;
        clear_log();
        send(64'd4);
        wait_rsp("G", lat);
        cmd_valid   = 1'b1;
        cmd_operand = 64'd6;
        for (int k = 0; k < 8; k++) begin
            chk("G_rsp_valid_hold", 128'(rsp_valid), 128'd1);
            chk("G_result_hold", rsp_result, 128'd24);
            chk("G_cmd_ready_low", 128'(cmd_ready), 128'd0);
            @(negedge clk);
        end
        chk("G_no_early_accept", 128'(log_addr.size()), 128'd7);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("G_ready_after_hs", 128'(cmd_ready), 128'd1);
        chk("G_rsp_dropped", 128'(rsp_valid), 128'd0);
        @(negedge clk);
        chk("G_second_accepted", 128'(cmd_ready), 128'd0);
        chk("G_second_addr", 128'(m_addr), 128'(BASE + 16'h0020));
        chk("G_second_dout", 128'(m_dout), 128'd6);
        wait_rsp("G2", lat);
        chk("G2_result", rsp_result, 128'd720);
        ack();

        // Asynchronous reset while waiting for OPDONE read data
        done_dly = 32'hFFFF_FFFF;
        clear_log();
        send(64'd9);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("H_in_poll_wt_req", 128'(m_req), 128'd1);
        chk("H_in_poll_wt_sel", 128'(m_sel), 128'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("H_rst_m_req", 128'(m_req), 128'd0);
        chk("H_rst_m_sel", 128'(m_sel), 128'd0);
        chk("H_rst_rsp_valid", 128'(rsp_valid), 128'd0);
        chk("H_rst_cmd_ready", 128'(cmd_ready), 128'd1);
        @(negedge clk);
        reset_n  = 1'b1;
        done_dly = 0;
        clear_log();
        send(64'd3);
        wait_rsp("H", lat);
        chk("H_result", rsp_result, 128'd6);
        chk("H_err", 128'(rsp_err), 128'd0);
        chk("H_nbeats", 128'(log_addr.size()), 128'd7);
        ack();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
